stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control and sequencing block for the stopwatch counter datapath in the FPGA top level.
- Conditions the two raw pushbuttons (start/stop, lap/clear) and paces the counter with a prescaled tick enable.
- Runs the IDLE/RUNNING/LAP/CLEAR mode machine, and holds a lap snapshot for display while the counter keeps running.
- The counter only counts, clears and wraps; every mode decision is made here.

Parameters:
- CLK_HZ, 100, input clock frequency in Hz (hz100 domain).
- TICK_HZ, 10, count-enable rate in Hz. PRESCALE = CLK_HZ/TICK_HZ, which must be an integer >= 2.
- DB_CYCLES, 2, number of consecutive stable synchronized samples needed to accept a button level change.
- COUNT_W, 5, width of the counter value.

Ports:
- clk, input, 1, system clock (hz100).
- nRst_i, input, 1, reset. Synchronous, active-low.
- start_stop_i, input, 1, raw pushbutton, asynchronous.
- lap_clear_i, input, 1, raw pushbutton, asynchronous.
- time_i, input, COUNT_W, live counter value from the datapath.
- count_en_o, output, 1, one-cycle increment enable to the datapath.
- clear_o, output, 1, synchronous clear to the datapath.
- mode_o, output, 2, current mode (ctrl_mode_t).
- freeze_o, output, 1, high while the display shows the lap snapshot.
- lap_o, output, COUNT_W, lap snapshot register.
- disp_o, output, COUNT_W, display value: lap_o if freeze_o, else time_i (combinational).

Behaviour:
- Reset: when nRst_i=0 at a clk edge, all state clears.
  - Reset values: mode_o=MODE_IDLE, count_en_o=0, clear_o=0, freeze_o=0, lap_o=0.
  - Prescaler=0. Synchronizer and debounce flops=0, debounced levels=0.
  - Reset mid-operation (any mode, mid-debounce, mid-prescale) takes effect at that edge. No pending event survives it.
- Button conditioning (one button_cond instance per button):
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after DB_CYCLES consecutive identical synchronized samples that differ from the current level.
  - A debounced rising edge produces a 1-cycle press pulse.
  - Latency: raw held high from edge N gives a pulse at edge N+2+DB_CYCLES.
  - Glitches shorter than DB_CYCLES samples give no pulse.
  - Holding a button gives exactly one pulse. Release produces no pulse.
- Mode FSM (registered; ss = start/stop pulse, lc = lap/clear pulse):
  - IDLE: ss -> RUNNING; lc -> CLEAR.
  - RUNNING: ss -> IDLE; lc -> LAP and lap_o <= time_i in the same edge.
  - LAP: ss -> IDLE (freeze released); lc -> RUNNING (freeze released).
  - CLEAR: unconditional -> IDLE after 1 cycle. Pulses arriving in CLEAR are dropped.
  - ss and lc in the same cycle: ss wins, lc is discarded.
- Outputs derived from the mode:
  - freeze_o = (mode==LAP), registered with the mode.
  - clear_o = (mode==CLEAR), exactly one cycle per clear.
  - lap_o is also cleared to 0 in CLEAR.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUNNING or LAP. Held at 0 in IDLE and CLEAR.
  - count_en_o = 1 for one cycle when prescaler==PRESCALE-1 and mode is RUNNING or LAP. The prescaler then wraps to 0.
  - First count_en_o comes PRESCALE cycles after entering RUNNING, i.e. the cycle where mode_o first shows RUNNING counts as cycle 1.
  - Stopping mid-period discards the partial period.
  - LAP->RUNNING does not reset the prescaler. The counter keeps running through LAP.
- Counter wrap (2^COUNT_W-1 -> 0) belongs to the datapath. The controller does not track it.
- count_en_o and clear_o are never high in the same cycle.

Decomposition:
- Package stopwatch_pkg:
  - ctrl_mode_t enum, 2 bits: MODE_IDLE=2'b00, MODE_RUNNING=2'b01, MODE_LAP=2'b10, MODE_CLEAR=2'b11.
  - Default constants CLK_HZ, TICK_HZ, DB_CYCLES, COUNT_W.
- Sub-module button_cond (synchronizer + debounce + rise pulse), parameterized by DB_CYCLES, instantiated twice.
- Prescaler and FSM stay inline.

Test Plan:
1. Reset/start (defaults; PRESCALE=10): hold nRst_i=0 for 3 cycles, outputs at reset values. Press start_stop_i for 6 cycles -> mode_o=RUNNING 5 edges after raw rise (pulse at +4, mode registers on the next edge). count_en_o pulses every 10 cycles, first on the 10th cycle of RUNNING.
2. Debounce: 1-cycle high glitch on start_stop_i -> no mode change. Hold high for 50 cycles -> exactly one transition.
3. Lap: in RUNNING with time_i=7, press lap_clear_i -> mode_o=LAP, lap_o=7, freeze_o=1. Drive time_i=9 -> disp_o stays 7 and count_en_o keeps pulsing. Press lap_clear_i again -> RUNNING, freeze_o=0, disp_o=9.
4. Clear: in IDLE with time_i=12, press lap_clear_i -> clear_o high exactly 1 cycle, then IDLE, lap_o=0, no count_en_o.
5. Simultaneous: both buttons rise on the same edge in RUNNING -> IDLE, lap_o unchanged, freeze_o=0.
6. Mid-operation reset: nRst_i=0 while in LAP with prescaler at 6 -> next edge shows mode_o=IDLE, freeze_o=0, lap_o=0. After release, the next start gives its first count_en_o a full 10 cycles later.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch controller.
package stopwatch_pkg;

  // Operating mode of the controller; values are visible on mode_o.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_RUNNING = 2'b01,
    MODE_LAP     = 2'b10,
    MODE_CLEAR   = 2'b11
  } ctrl_mode_t;

  localparam int unsigned CLK_HZ    = 100;
  localparam int unsigned TICK_HZ   = 10;
  localparam int unsigned DB_CYCLES = 2;
  localparam int unsigned COUNT_W   = 5;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Controller <-> counter datapath bundle.
//   time_i     : live counter value from the datapath
//   count_en_o : one-cycle increment enable
//   clear_o    : synchronous clear
//   mode_o     : current controller mode
//   freeze_o   : display shows the lap snapshot
//   lap_o      : lap snapshot
//   disp_o     : display value (combinational)
interface stopwatch_ctrl_if #(
  parameter int unsigned COUNT_W = stopwatch_pkg::COUNT_W
);
  import stopwatch_pkg::*;

  logic [COUNT_W-1:0] time_i;
  logic               count_en_o;
  logic               clear_o;
  ctrl_mode_t         mode_o;
  logic               freeze_o;
  logic [COUNT_W-1:0] lap_o;
  logic [COUNT_W-1:0] disp_o;

  // Controller side.
  modport master (
    input  time_i,
    output count_en_o, clear_o, mode_o, freeze_o, lap_o, disp_o
  );

  // Counter datapath / display side.
  modport slave (
    output time_i,
    input  count_en_o, clear_o, mode_o, freeze_o, lap_o, disp_o
  );

endinterface

// File: rtl/stopwatch_ctrl_button_cond.sv
// Pushbutton conditioning: 2-flop synchronizer, stability-count debounce,
// and a one-cycle pulse on each accepted rising level.
//   clk, nRst_i : clock, synchronous active-low reset
//   btn_i       : raw asynchronous pushbutton
//   press_o     : registered one-cycle press pulse
module button_cond #(
  parameter int unsigned DB_CYCLES = stopwatch_pkg::DB_CYCLES
) (
  input  logic clk,
  input  logic nRst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Count consecutive synchronized samples that disagree with the level;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, mode FSM, lap snapshot and the
// tick prescaler that paces the external counter.
//   clk          : system clock
//   nRst_i       : synchronous active-low reset
//   start_stop_i : raw start/stop pushbutton
//   lap_clear_i  : raw lap/clear pushbutton
//   dp           : datapath bundle (time in; enable, clear, mode, lap, display out)
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ    = stopwatch_pkg::CLK_HZ,
  parameter int unsigned TICK_HZ   = stopwatch_pkg::TICK_HZ,
  parameter int unsigned DB_CYCLES = stopwatch_pkg::DB_CYCLES,
  parameter int unsigned COUNT_W   = stopwatch_pkg::COUNT_W
) (
  input  logic                    clk,
  input  logic                    nRst_i,
  input  logic                    start_stop_i,
  input  logic                    lap_clear_i,
  stopwatch_ctrl_if.master        dp
);
  import stopwatch_pkg::*;

  // PRESCALE must be an integer >= 2.
  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W  = $clog2(PRESCALE);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  logic ss_pulse, lc_pulse;

  ctrl_mode_t         mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               count_en_q, count_en_d;
  logic               clear_q, clear_d;
  logic               freeze_q, freeze_d;
  logic [COUNT_W-1:0] lap_q, lap_d;
  logic               run_q, run_d;

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_ss_cond (
    .clk    (clk),
    .nRst_i (nRst_i),
    .btn_i  (start_stop_i),
    .press_o(ss_pulse)
  );

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_lc_cond (
    .clk    (clk),
    .nRst_i (nRst_i),
    .btn_i  (lap_clear_i),
    .press_o(lc_pulse)
  );

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      mode_q <= MODE_IDLE;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next-state logic; start/stop has priority over lap/clear.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_IDLE: begin
        if (ss_pulse)      mode_d = MODE_RUNNING;
        else if (lc_pulse) mode_d = MODE_CLEAR;
      end
      MODE_RUNNING: begin
        if (ss_pulse)      mode_d = MODE_IDLE;
        else if (lc_pulse) mode_d = MODE_LAP;
      end
      MODE_LAP: begin
        if (ss_pulse)      mode_d = MODE_IDLE;
        else if (lc_pulse) mode_d = MODE_RUNNING;
      end
      MODE_CLEAR: mode_d = MODE_IDLE;
      default:    mode_d = MODE_IDLE;
    endcase
  end

  // Output/next-value logic, computed from the next mode so every output
  // register changes on the same edge as mode_q.
  always_comb begin
    run_q      = (mode_q == MODE_RUNNING) || (mode_q == MODE_LAP);
    run_d      = (mode_d == MODE_RUNNING) || (mode_d == MODE_LAP);
    presc_d    = '0;
    lap_d      = lap_q;
    clear_d    = (mode_d == MODE_CLEAR);
    freeze_d   = (mode_d == MODE_LAP);
    // Entering RUNNING from IDLE restarts the period; LAP<->RUNNING keeps it.
    if (run_q && run_d) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
    end
    count_en_d = run_d && (presc_d == PRESC_MAX);
    if (mode_d == MODE_CLEAR) begin
      lap_d = '0;
    end else if ((mode_q == MODE_RUNNING) && (mode_d == MODE_LAP)) begin
      lap_d = dp.time_i;
    end
  end

  // Prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      presc_q    <= '0;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
      freeze_q   <= 1'b0;
      lap_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      count_en_q <= count_en_d;
      clear_q    <= clear_d;
      freeze_q   <= freeze_d;
      lap_q      <= lap_d;
    end
  end

  assign dp.count_en_o = count_en_q;
  assign dp.clear_o    = clear_q;
  assign dp.mode_o     = mode_q;
  assign dp.freeze_o   = freeze_q;
  assign dp.lap_o      = lap_q;
  // Display mux is combinational so the live value is never a cycle stale.
  assign dp.disp_o     = freeze_q ? lap_q : dp.time_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with default parameters
// (PRESCALE=10, DB_CYCLES=2, COUNT_W=5).
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk;
  logic nRst_i;
  logic start_stop_i;
  logic lap_clear_i;

  int tests_run;
  int tests_failed;

  stopwatch_ctrl_if #(.COUNT_W(5)) sw_if ();

  stopwatch_ctrl dut (
    .clk         (clk),
    .nRst_i      (nRst_i),
    .start_stop_i(start_stop_i),
    .lap_clear_i (lap_clear_i),
    .dp          (sw_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    nRst_i = 1'b0;
    start_stop_i = 1'b0;
    lap_clear_i = 1'b0;
    sw_if.time_i = 5'd3;
    tick(3);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL reset_mode: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
    tests_run++; if (sw_if.count_en_o !== 1'b0) begin tests_failed++; $display("FAIL reset_count_en: got %0b expected 0", sw_if.count_en_o); end
    tests_run++; if (sw_if.clear_o !== 1'b0) begin tests_failed++; $display("FAIL reset_clear: got %0b expected 0", sw_if.clear_o); end
    tests_run++; if (sw_if.freeze_o !== 1'b0) begin tests_failed++; $display("FAIL reset_freeze: got %0b expected 0", sw_if.freeze_o); end
    tests_run++; if (sw_if.lap_o !== 5'd0) begin tests_failed++; $display("FAIL reset_lap: got %0d expected 0", sw_if.lap_o); end
    tests_run++; if (sw_if.disp_o !== 5'd3) begin tests_failed++; $display("FAIL reset_disp: got %0d expected 3", sw_if.disp_o); end
    nRst_i = 1'b1;
    tick(2);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL post_reset_mode: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
  endtask

  task automatic test_start();
    int  n;
    bit  found;
    start_stop_i = 1'b1;
    tick(4);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL start_latency_early: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
    tick(1);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL start_mode: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    // First enable on the 10th cycle of RUNNING.
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      tick(1); n++;
      if (n == 1) start_stop_i = 1'b0;
      if (sw_if.count_en_o === 1'b1) found = 1'b1;
    end
    tests_run++; if (n !== 9) begin tests_failed++; $display("FAIL first_count_en: got %0d cycles expected 9", n); end
    tick(1);
    tests_run++; if (sw_if.count_en_o !== 1'b0) begin tests_failed++; $display("FAIL count_en_width: got %0b expected 0", sw_if.count_en_o); end
    n = 1; found = 1'b0;
    while (!found && n < 20) begin
      tick(1); n++;
      if (sw_if.count_en_o === 1'b1) found = 1'b1;
    end
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL count_en_period: got %0d expected 10", n); end
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL release_no_pulse: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
  endtask

  task automatic test_debounce();
    int changes;
    ctrl_mode_t prev;
    start_stop_i = 1'b1;
    tick(1);
    start_stop_i = 1'b0;
    tick(8);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL glitch_ignored: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    changes = 0;
    prev = sw_if.mode_o;
    start_stop_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) start_stop_i = 1'b0;
      tick(1);
      if (sw_if.mode_o !== prev) changes++;
      prev = sw_if.mode_o;
    end
    tests_run++; if (changes !== 1) begin tests_failed++; $display("FAIL hold_one_transition: got %0d expected 1", changes); end
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL hold_final_mode: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
  endtask

  task automatic test_lap();
    int ens;
    sw_if.time_i = 5'd7;
    start_stop_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL lap_setup_run: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    tick(1); start_stop_i = 1'b0; tick(4);
    lap_clear_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_LAP) begin tests_failed++; $display("FAIL lap_mode: got %0d expected %0d", sw_if.mode_o, MODE_LAP); end
    tests_run++; if (sw_if.lap_o !== 5'd7) begin tests_failed++; $display("FAIL lap_snapshot: got %0d expected 7", sw_if.lap_o); end
    tests_run++; if (sw_if.freeze_o !== 1'b1) begin tests_failed++; $display("FAIL lap_freeze: got %0b expected 1", sw_if.freeze_o); end
    tick(1); lap_clear_i = 1'b0;
    sw_if.time_i = 5'd9;
    #1;
    tests_run++; if (sw_if.disp_o !== 5'd7) begin tests_failed++; $display("FAIL lap_disp_frozen: got %0d expected 7", sw_if.disp_o); end
    ens = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (sw_if.count_en_o === 1'b1) ens++;
    end
    tests_run++; if (ens < 2) begin tests_failed++; $display("FAIL lap_keeps_counting: got %0d enables expected at least 2", ens); end
    lap_clear_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL unlap_mode: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    tests_run++; if (sw_if.freeze_o !== 1'b0) begin tests_failed++; $display("FAIL unlap_freeze: got %0b expected 0", sw_if.freeze_o); end
    tests_run++; if (sw_if.disp_o !== 5'd9) begin tests_failed++; $display("FAIL unlap_disp: got %0d expected 9", sw_if.disp_o); end
    tick(1); lap_clear_i = 1'b0; tick(4);
  endtask

  task automatic test_simultaneous();
    start_stop_i = 1'b1;
    lap_clear_i = 1'b1;
    tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL simul_mode: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
    tests_run++; if (sw_if.lap_o !== 5'd7) begin tests_failed++; $display("FAIL simul_lap: got %0d expected 7", sw_if.lap_o); end
    tests_run++; if (sw_if.freeze_o !== 1'b0) begin tests_failed++; $display("FAIL simul_freeze: got %0b expected 0", sw_if.freeze_o); end
    tick(1);
    start_stop_i = 1'b0;
    lap_clear_i = 1'b0;
    tick(4);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL simul_dropped_lc: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
  endtask

  task automatic test_clear();
    int ens;
    sw_if.time_i = 5'd12;
    lap_clear_i = 1'b1;
    tick(4);
    tests_run++; if (sw_if.clear_o !== 1'b0) begin tests_failed++; $display("FAIL clear_early: got %0b expected 0", sw_if.clear_o); end
    tick(1);
    tests_run++; if (sw_if.mode_o !== MODE_CLEAR) begin tests_failed++; $display("FAIL clear_mode: got %0d expected %0d", sw_if.mode_o, MODE_CLEAR); end
    tests_run++; if (sw_if.clear_o !== 1'b1) begin tests_failed++; $display("FAIL clear_pulse: got %0b expected 1", sw_if.clear_o); end
    tests_run++; if (sw_if.lap_o !== 5'd0) begin tests_failed++; $display("FAIL clear_lap: got %0d expected 0", sw_if.lap_o); end
    tick(1);
    tests_run++; if (sw_if.clear_o !== 1'b0) begin tests_failed++; $display("FAIL clear_one_cycle: got %0b expected 0", sw_if.clear_o); end
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL clear_to_idle: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
    lap_clear_i = 1'b0;
    ens = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (sw_if.count_en_o === 1'b1) ens++;
    end
    tests_run++; if (ens !== 0) begin tests_failed++; $display("FAIL clear_no_count_en: got %0d expected 0", ens); end
    tests_run++; if (sw_if.disp_o !== 5'd12) begin tests_failed++; $display("FAIL idle_disp: got %0d expected 12", sw_if.disp_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    // Reach LAP with the prescaler at 6 (16 cycles after RUNNING first shows).
    start_stop_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL mid_setup_run: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    tick(1); start_stop_i = 1'b0; tick(4);
    lap_clear_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_LAP) begin tests_failed++; $display("FAIL mid_setup_lap: got %0d expected %0d", sw_if.mode_o, MODE_LAP); end
    tests_run++; if (sw_if.lap_o !== 5'd12) begin tests_failed++; $display("FAIL mid_setup_snap: got %0d expected 12", sw_if.lap_o); end
    tick(1); lap_clear_i = 1'b0; tick(5);
    nRst_i = 1'b0;
    tick(1);
    tests_run++; if (sw_if.mode_o !== MODE_IDLE) begin tests_failed++; $display("FAIL mid_reset_mode: got %0d expected %0d", sw_if.mode_o, MODE_IDLE); end
    tests_run++; if (sw_if.freeze_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_freeze: got %0b expected 0", sw_if.freeze_o); end
    tests_run++; if (sw_if.lap_o !== 5'd0) begin tests_failed++; $display("FAIL mid_reset_lap: got %0d expected 0", sw_if.lap_o); end
    nRst_i = 1'b1;
    tick(3);
    tests_run++; if (sw_if.count_en_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_no_en: got %0b expected 0", sw_if.count_en_o); end
    start_stop_i = 1'b1; tick(5);
    tests_run++; if (sw_if.mode_o !== MODE_RUNNING) begin tests_failed++; $display("FAIL restart_mode: got %0d expected %0d", sw_if.mode_o, MODE_RUNNING); end
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      tick(1); n++;
      if (n == 1) start_stop_i = 1'b0;
      if (sw_if.count_en_o === 1'b1) found = 1'b1;
    end
    tests_run++; if (n !== 9) begin tests_failed++; $display("FAIL restart_first_en: got %0d cycles expected 9", n); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_start();
    test_debounce();
    test_lap();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
